// File: rtl/goldschmidt_issue_if.sv
// Operand/quotient handshake bundle for goldschmidt_issue.
// master = operand source and quotient consumer; slave = the issue block.
interface goldschmidt_issue_if #(
    parameter int WIDTH = 29
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_den;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic             out_dz;

    modport master (
        output in_valid, in_num, in_den, out_ready,
        input  in_ready, out_valid, out_quot, out_dz
    );

    modport slave (
        input  in_valid, in_num, in_den, out_ready,
        output in_ready, out_valid, out_quot, out_dz
    );
endinterface

// File: rtl/goldschmidt_issue.sv
// On-demand sequencer for the Goldschmidt divider: one ITERS-cycle schedule per operand pair.
// Optional GOLDSCHMIDT_DZ_CHECK_EN: zero denominators bypass the divider and flag out_dz.
module goldschmidt_issue #(
    parameter int WIDTH = 29,
    parameter int ITERS = 12
) (
    input  logic             clk,
    input  logic             reset,
    goldschmidt_issue_if.slave io,
    output logic             busy,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    output logic             div_mode,
    output logic             div_stage,
    input  logic [WIDTH-1:0] div_quot
);
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             out_valid_q;
    logic [WIDTH-1:0] quot_q;
    logic             accept;
    logic             dz_hit;

    // DONE can accept a new pair in the same cycle its result is retired.
    assign io.in_ready  = (state == IDLE) || ((state == DONE) && io.out_ready);
    assign accept       = io.in_valid && io.in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_quot  = quot_q;
    assign busy         = (state == RUN);
    assign div_mode     = (state == RUN) && (cnt >= CW'(2));
    assign div_stage    = (state == RUN) && cnt[0];

`ifdef GOLDSCHMIDT_DZ_CHECK_EN
    logic dz_q;
    assign dz_hit    = (io.in_den == '0);
    assign io.out_dz = dz_q;
`else
    assign dz_hit    = 1'b0;
    assign io.out_dz = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            div_num     <= '0;
            div_den     <= '0;
`ifdef GOLDSCHMIDT_DZ_CHECK_EN
            dz_q        <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (cnt == LAST) begin
                        quot_q      <= div_quot;
                        out_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
`ifdef GOLDSCHMIDT_DZ_CHECK_EN
                        dz_q        <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // Retire first; a same-cycle accept below overrides the IDLE target.
                    if ((state == DONE) && io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                    if (accept) begin
                        if (dz_hit) begin
                            quot_q      <= '1;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
`ifdef GOLDSCHMIDT_DZ_CHECK_EN
                            dz_q        <= 1'b1;
`endif
                        end else begin
                            div_num     <= io.in_num;
                            div_den     <= io.in_den;
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
            endcase
        end
    end
endmodule
